serial_frame_rx: RTL and testbench



---
 rtl/serial_frame_rx.sv | 96 +++++++++
 tb/tb_serial_frame_rx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver: start bit, MSB-first data, optional even parity, stop bit
module serial_frame_rx #(
   parameter int DATA_W    = 4,
   parameter int PARITY_EN = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              SI,
   input  logic              bit_en,
   output logic [DATA_W-1:0] dout,
   output logic              valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int CW = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic [DATA_W-1:0] dout_n;
   logic              par, par_n;
   logic              valid_n, perr_n, ferr_n, busy_n;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         dout       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         shreg      <= shreg_n;
         par        <= par_n;
         dout       <= dout_n;
         valid      <= valid_n;
         parity_err <= perr_n;
         frame_err  <= ferr_n;
         busy       <= busy_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shreg_n = shreg;
      par_n   = par;
      dout_n  = dout;
      valid_n = 1'b0;
      perr_n  = 1'b0;
      ferr_n  = 1'b0;
      if (bit_en) begin
         case (state)
            IDLE: begin
               if (!SI) begin
                  state_n = DATA;
                  cnt_n   = '0;
               end
            end
            DATA: begin
               shreg_n = {shreg[DATA_W-2:0], SI};
               cnt_n   = cnt + 1'b1;
               if (cnt == CW'(DATA_W - 1))
                  state_n = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
               par_n   = SI;
               state_n = STOP;
            end
            STOP: begin
               state_n = IDLE;
               // A parity mismatch still delivers the word; only a bad stop bit discards it.
               if (SI) begin
                  dout_n  = shreg;
                  valid_n = 1'b1;
                  perr_n  = (PARITY_EN != 0) ? ((^shreg) ^ par) : 1'b0;
               end else begin
                  ferr_n  = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - directed self-checking bench for serial_frame_rx
module tb_serial_frame_rx;

   logic       clk = 1'b0;
   logic       rstn, SI, bit_en;
   logic [3:0] dout_a, dout_b;
   logic       valid_a, perr_a, ferr_a, busy_a;
   logic       valid_b, perr_b, ferr_b, busy_b;

   int checks = 0;
   int failures = 0;
   int vcnt, fcnt, bcnt, vcnt_b;

   always #5 clk = ~clk;

   serial_frame_rx #(.DATA_W(4), .PARITY_EN(1)) dut_a (
      .clk(clk), .rstn(rstn), .SI(SI), .bit_en(bit_en),
      .dout(dout_a), .valid(valid_a), .parity_err(perr_a),
      .frame_err(ferr_a), .busy(busy_a)
   );

   serial_frame_rx #(.DATA_W(4), .PARITY_EN(0)) dut_b (
      .clk(clk), .rstn(rstn), .SI(SI), .bit_en(bit_en),
      .dout(dout_b), .valid(valid_b), .parity_err(perr_b),
      .frame_err(ferr_b), .busy(busy_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (valid_a) vcnt++;
      if (ferr_a) fcnt++;
      if (busy_a) bcnt++;
      if (valid_b) vcnt_b++;
   endtask

   task automatic clr();
      vcnt = 0; fcnt = 0; bcnt = 0; vcnt_b = 0;
   endtask

   task automatic send(input logic [15:0] seq, input int n);
      for (int i = 0; i < n; i++) begin
         SI = seq[n-1-i];
         bit_en = 1'b1;
         step();
      end
      bit_en = 1'b0;
      SI = 1'b1;
   endtask

   task automatic send_gap(input logic [15:0] seq, input int n);
      for (int i = 0; i < n; i++) begin
         SI = seq[n-1-i];
         bit_en = 1'b1;
         step();
         if (i < n - 1) begin
            for (int g = 0; g < 2; g++) begin
               bit_en = 1'b0;
               SI = 1'($urandom_range(0, 1));
               step();
               chk("gap_busy", busy_a, 1'b1);
            end
         end
      end
      bit_en = 1'b0;
      SI = 1'b1;
   endtask

   task automatic idle();
      bit_en = 1'b0;
      SI = 1'b1;
      step();
   endtask

   initial begin
      clr();
      rstn = 1'b0; SI = 1'b1; bit_en = 1'b0;
      step(); step();
      chk("rst_dout", dout_a, 4'h0);
      chk("rst_valid", valid_a, 1'b0);
      chk("rst_perr", perr_a, 1'b0);
      chk("rst_ferr", ferr_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      rstn = 1'b1;
      idle();

      // good frame
      clr();
      send(16'b0101111, 7);
      chk("good_valid", valid_a, 1'b1);
      chk("good_dout", dout_a, 4'b1011);
      chk("good_perr", perr_a, 1'b0);
      chk("good_ferr", ferr_a, 1'b0);
      chk("good_busy_cycles", bcnt, 6);
      idle();
      chk("good_valid_clear", valid_a, 1'b0);
      chk("good_valid_count", vcnt, 1);

      // bad parity still delivers
      send(16'b0101101, 7);
      chk("badpar_valid", valid_a, 1'b1);
      chk("badpar_dout", dout_a, 4'b1011);
      chk("badpar_perr", perr_a, 1'b1);
      idle();
      chk("badpar_perr_clear", perr_a, 1'b0);
      chk("badpar_valid_clear", valid_a, 1'b0);

      // framing error
      clr();
      send(16'b0011000, 7);
      chk("ferr_pulse", ferr_a, 1'b1);
      chk("ferr_valid", valid_a, 1'b0);
      chk("ferr_dout", dout_a, 4'b1011);
      chk("ferr_perr", perr_a, 1'b0);
      chk("ferr_busy", busy_a, 1'b0);
      idle();
      chk("ferr_clear", ferr_a, 1'b0);
      chk("ferr_valid_count", vcnt, 0);

      // gapped strobes
      clr();
      send_gap(16'b0101111, 7);
      chk("gap_valid", valid_a, 1'b1);
      chk("gap_dout", dout_a, 4'b1011);
      chk("gap_perr", perr_a, 1'b0);
      idle();
      chk("gap_valid_count", vcnt, 1);
      chk("gap_busy_cycles", bcnt, 18);

      // reset mid-frame
      clr();
      send(16'b010, 3);
      chk("mid_busy", busy_a, 1'b1);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("abort_busy", busy_a, 1'b0);
      chk("abort_dout", dout_a, 4'h0);
      chk("abort_valid", valid_a, 1'b0);
      chk("abort_ferr", ferr_a, 1'b0);
      clr();
      for (int i = 0; i < 10; i++) begin
         SI = 1'b1;
         bit_en = 1'b1;
         step();
      end
      bit_en = 1'b0;
      chk("idle_valid_count", vcnt, 0);
      chk("idle_ferr_count", fcnt, 0);
      chk("idle_busy_cycles", bcnt, 0);
      send(16'b0011001, 7);
      chk("post_valid", valid_a, 1'b1);
      chk("post_dout", dout_a, 4'b0110);
      chk("post_perr", perr_a, 1'b0);
      idle();

      // PARITY_EN=0, back-to-back
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      clr();
      send(16'b011001, 6);
      chk("np1_valid", valid_b, 1'b1);
      chk("np1_dout", dout_b, 4'b1100);
      chk("np1_perr", perr_b, 1'b0);
      send(16'b000011, 6);
      chk("np2_valid", valid_b, 1'b1);
      chk("np2_dout", dout_b, 4'b0001);
      chk("np2_perr", perr_b, 1'b0);
      idle();
      chk("np_valid_clear", valid_b, 1'b0);
      chk("np_valid_count", vcnt_b, 2);
      chk("np_ferr", ferr_b, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
